datapath_param: RTL and testbench
=================================

# datapath_param

Parametrised datapath: NREG×WIDTH register file, constant/register B-operand mux, a 16-op function unit, and a result/Data_in writeback mux. Adds registered status flags and a multi-cycle logical shift-by-N with a busy/done handshake. Replaces the fixed 4×32 add-only datapath. Sits between the control unit, which drives the selects and function code, and the memory interface, which consumes Address_out and Data_out and supplies Data_in.

## Interface
- WIDTH, 32: data width, ≥8, power of two
- NREG, 4: register count, power of two ≥2; RA = log2(NREG)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears all state
- load_enable  in  1  request writeback/operation this cycle
- dest_select, A_select, B_select  in  RA each  register addresses
- fs  in  4  function select
- mb_select  in  1  0: B = B_data; 1: B = constant_in
- md_select  in  1  0: write F; 1: write Data_in
- constant_in, Data_in  in  WIDTH each
- Address_out  out  WIDTH  A_data, combinational
- Data_out  out  WIDTH  B (post-mux), combinational
- function_result  out  WIDTH  writeback value (md mux output), combinational
- flags  out  4  {V,C,N,Z}, registered
- busy  out  1  multi-cycle shift in progress, registered
- done  out  1  one-cycle pulse on shift writeback

## Operation
- fs: 0 ADD A+B; 1 SUB A+~B+1; 2 INC A+1; 3 DEC A−1; 4 AND; 5 OR; 6 XOR; 7 NOT A; 8 PASS B; 9 SHL1 A; 10 SHR1 A (logical); 12 SHLN; 13 SHRN; 11/14/15 PASS A.
- Arithmetic computed WIDTH+1 wide; C = bit WIDTH (SUB: C=1 means no borrow); V = signed overflow on ops 0–3, else 0; SHL1/SHR1 C = bit shifted out; N = MSB; Z = result==0.
- Single-cycle op, load_enable=1, busy=0: reg[dest_select] ← function_result at the edge. Flags update only when md_select=0; Data_in loads leave flags unchanged.
- SHLN/SHRN, load_enable=1, busy=0: amount n = B[log2(WIDTH)−1:0]; md_select ignored.
  - n=0: single-cycle write of A; flags C=0, V=0; no busy, no done.
  - n>0: latch A, n, dest, direction; busy=1; each cycle shift one bit, count−1; on the count 1→0 edge write reg[dest], flags {V=0, C=last bit out, N, Z}, busy=0, done=1.
- FSM: IDLE → SHIFT on multi-cycle accept; SHIFT → IDLE at writeback.
- While busy=1, load_enable is ignored: no write, no flag change, no queueing. Combinational outputs still reflect current selects.
- A or B reading the shift destination during SHIFT returns the old value; no forwarding.
- Read of the register written the same edge returns the old value. Writes become visible next cycle.

## Timing
- Reset values: all registers 0, flags 0, busy 0, done 0, FSM IDLE. Reset during SHIFT aborts with no writeback.
- Single-cycle op latency 1 edge.
- Shift by n>0: busy high n cycles. Result and done appear on the nth edge after the accept edge.
- busy is registered, so load_enable in the cycle busy falls is still ignored. Next accept is at the following edge. done coincides with the first busy=0 cycle.

## Structure
- Package datapath_pkg: fs codes as a 4-bit enum, FSM state enum, flag bit indices.
- Sub-module register_file_param (WIDTH, NREG): async-reset, 2 combinational read ports, 1 write port.
- Function unit, muxes, shift FSM and flag register live in the top.

## Test plan
- Reset: WIDTH=32, NREG=8, hold reset=0 with toggling controls → all regs read 0, flags=0000, busy=0.
- ADD overflow: r1=0x7FFFFFFF, constant_in=1, mb=1, fs=0 → r2=0x80000000, flags V=1,C=0,N=1,Z=0. SUB r1−r1 → 0, Z=1, C=1.
- Data_in load: md=1, Data_in=0xDEADBEEF → dest=0xDEADBEEF, flags unchanged from prior op.
- SHLN: r3=0x80000001, constant_in=4, fs=12 → busy 4 cycles, r3=0x00000010, C=0 (last bit out is bit 28), done 1 cycle. SHRN by 1 of 0x3 → 0x1, C=1.
- Busy ignore: issue ADD to r4 during SHRN → r4 unchanged. Issue in the busy-falling cycle → ignored; reissue next cycle → written.
- Reset mid-shift: assert reset at cycle 2 of a 5-cycle SHRN → dest=0, busy=0, no done pulse.

Source files
------------

// File: rtl/datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module   : datapath_pkg
// Purpose  : Shared types for the parametrised datapath: function-select
//            codes, shift FSM states and status-flag bit positions.
// Ports    : (package, none)
// Revision : 1.0  initial release
// ============================================================================
package datapath_pkg;

  typedef enum logic [3:0] {
    FS_ADD    = 4'd0,
    FS_SUB    = 4'd1,
    FS_INC    = 4'd2,
    FS_DEC    = 4'd3,
    FS_AND    = 4'd4,
    FS_OR     = 4'd5,
    FS_XOR    = 4'd6,
    FS_NOT    = 4'd7,
    FS_PASSB  = 4'd8,
    FS_SHL1   = 4'd9,
    FS_SHR1   = 4'd10,
    FS_PASSA0 = 4'd11,
    FS_SHLN   = 4'd12,
    FS_SHRN   = 4'd13,
    FS_PASSA1 = 4'd14,
    FS_PASSA2 = 4'd15
  } fs_e;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bit positions inside the {V,C,N,Z} flag vector
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  function automatic logic is_shift_n(input fs_e fs);
    return (fs == FS_SHLN) || (fs == FS_SHRN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/register_file_param.sv
`default_nettype none
// ============================================================================
// Module   : register_file_param
// Purpose  : NREG x WIDTH register file, asynchronous active-low clear,
//            two combinational read ports and one synchronous write port.
// Ports    : clk, reset (async, active-low)
//            i_we / i_waddr / i_wdata        : write port
//            i_raddr_a / i_raddr_b           : read addresses
//            o_rdata_a / o_rdata_b           : read data (combinational)
// Revision : 1.0  initial release
// ============================================================================
module register_file_param #(
  parameter  int WIDTH = 32,
  parameter  int NREG  = 4,
  localparam int RA    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_we,
  input  logic [RA-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [RA-1:0]    i_raddr_a,
  input  logic [RA-1:0]    i_raddr_b,
  output logic [WIDTH-1:0] o_rdata_a,
  output logic [WIDTH-1:0] o_rdata_b
);

  logic [WIDTH-1:0] r_regs [NREG];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // No write-through: a read of the register being written sees the old value
  assign o_rdata_a = r_regs[i_raddr_a];
  assign o_rdata_b = r_regs[i_raddr_b];

endmodule
`default_nettype wire

// File: rtl/datapath_param.sv
`default_nettype none
// ============================================================================
// Module   : datapath_param
// Purpose  : Parametrised datapath: register file, B-operand mux, 16-op
//            function unit, writeback mux, registered {V,C,N,Z} flags and a
//            multi-cycle logical shift-by-N with busy/done handshake.
// Ports    : clk, reset (async, active-low)
//            i_load_enable                   : accept an operation this cycle
//            i_dest_select/i_a_select/i_b_select : register addresses
//            i_fs                            : function select
//            i_mb_select                     : 0 B=reg, 1 B=i_constant_in
//            i_md_select                     : 0 write F, 1 write i_data_in
//            i_constant_in, i_data_in        : data inputs
//            o_address_out                   : A operand (combinational)
//            o_data_out                      : B operand (combinational)
//            o_function_result               : writeback value (combinational)
//            o_flags                         : {V,C,N,Z} (registered)
//            o_busy, o_done                  : shift handshake (registered)
// Revision : 1.0  initial release
// ============================================================================
module datapath_param
  import datapath_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int NREG  = 4,
  localparam int RA    = $clog2(NREG),
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load_enable,
  input  logic [RA-1:0]    i_dest_select,
  input  logic [RA-1:0]    i_a_select,
  input  logic [RA-1:0]    i_b_select,
  input  logic [3:0]       i_fs,
  input  logic             i_mb_select,
  input  logic             i_md_select,
  input  logic [WIDTH-1:0] i_constant_in,
  input  logic [WIDTH-1:0] i_data_in,
  output logic [WIDTH-1:0] o_address_out,
  output logic [WIDTH-1:0] o_data_out,
  output logic [WIDTH-1:0] o_function_result,
  output logic [3:0]       o_flags,
  output logic             o_busy,
  output logic             o_done
);

  localparam int             MSB      = WIDTH - 1;
  localparam logic [WIDTH:0] ONE_EXT  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [SW-1:0]  CNT_LAST = SW'(1);

  // --------------------------------------------------------------------------
  // Operand path
  // --------------------------------------------------------------------------
  fs_e              w_fs;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b_reg;
  logic [WIDTH-1:0] w_b;
  logic             w_is_shn;
  logic [SW-1:0]    w_n;

  logic             w_we;
  logic [RA-1:0]    w_waddr;
  logic [WIDTH-1:0] w_wdata;

  register_file_param #(
    .WIDTH (WIDTH),
    .NREG  (NREG)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (i_a_select),
    .i_raddr_b (i_b_select),
    .o_rdata_a (w_a),
    .o_rdata_b (w_b_reg)
  );

  assign w_fs          = fs_e'(i_fs);
  assign w_b           = i_mb_select ? i_constant_in : w_b_reg;
  assign w_is_shn      = is_shift_n(w_fs);
  assign w_n           = w_b[SW-1:0];
  assign o_address_out = w_a;
  assign o_data_out    = w_b;

  // --------------------------------------------------------------------------
  // Function unit: arithmetic is done one bit wider so the carry drops out
  // --------------------------------------------------------------------------
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_f;
  logic             w_c;
  logic             w_v;

  always_comb begin
    w_sum = '0;
    w_f   = w_a;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (w_fs)
      FS_ADD: begin
        w_sum = {1'b0, w_a} + {1'b0, w_b};
        w_f   = w_sum[MSB:0];
        w_c   = w_sum[WIDTH];
        w_v   = (w_a[MSB] == w_b[MSB]) && (w_f[MSB] != w_a[MSB]);
      end
      FS_SUB: begin
        // C=1 means no borrow
        w_sum = {1'b0, w_a} + {1'b0, ~w_b} + ONE_EXT;
        w_f   = w_sum[MSB:0];
        w_c   = w_sum[WIDTH];
        w_v   = (w_a[MSB] != w_b[MSB]) && (w_f[MSB] != w_a[MSB]);
      end
      FS_INC: begin
        w_sum = {1'b0, w_a} + ONE_EXT;
        w_f   = w_sum[MSB:0];
        w_c   = w_sum[WIDTH];
        w_v   = !w_a[MSB] && w_f[MSB];
      end
      FS_DEC: begin
        // Plain wide subtraction: bit WIDTH is set only when A wraps from 0
        w_sum = {1'b0, w_a} - ONE_EXT;
        w_f   = w_sum[MSB:0];
        w_c   = w_sum[WIDTH];
        w_v   = w_a[MSB] && !w_f[MSB];
      end
      FS_AND:   w_f = w_a & w_b;
      FS_OR:    w_f = w_a | w_b;
      FS_XOR:   w_f = w_a ^ w_b;
      FS_NOT:   w_f = ~w_a;
      FS_PASSB: w_f = w_b;
      FS_SHL1: begin
        w_f = {w_a[MSB-1:0], 1'b0};
        w_c = w_a[MSB];
      end
      FS_SHR1: begin
        w_f = {1'b0, w_a[MSB:1]};
        w_c = w_a[0];
      end
      // SHLN/SHRN present A here; that is what a zero-length shift writes
      default:  w_f = w_a;
    endcase
  end

  // Shift ops always write the function-unit output, whatever md_select says
  assign o_function_result = (i_md_select && !w_is_shn) ? i_data_in : w_f;

  // --------------------------------------------------------------------------
  // Shift FSM, writeback control and flag update
  // --------------------------------------------------------------------------
  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_sh_val;
  logic [WIDTH-1:0] w_sh_val_nxt;
  logic [SW-1:0]    r_sh_cnt;
  logic [SW-1:0]    w_sh_cnt_nxt;
  logic [RA-1:0]    r_sh_dest;
  logic [RA-1:0]    w_sh_dest_nxt;
  logic             r_sh_right;
  logic             w_sh_right_nxt;
  logic [3:0]       r_flags;
  logic [3:0]       w_flags_nxt;
  logic             r_done;
  logic             w_done_nxt;

  logic [WIDTH-1:0] w_step;
  logic             w_out_bit;

  assign w_step    = r_sh_right ? {1'b0, r_sh_val[MSB:1]} : {r_sh_val[MSB-1:0], 1'b0};
  assign w_out_bit = r_sh_right ? r_sh_val[0] : r_sh_val[MSB];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_we           = 1'b0;
    w_waddr        = i_dest_select;
    w_wdata        = o_function_result;
    w_flags_nxt    = r_flags;
    w_done_nxt     = 1'b0;
    w_sh_val_nxt   = r_sh_val;
    w_sh_cnt_nxt   = r_sh_cnt;
    w_sh_dest_nxt  = r_sh_dest;
    w_sh_right_nxt = r_sh_right;
    case (r_state)
      ST_IDLE: begin
        if (i_load_enable) begin
          if (w_is_shn && (w_n != '0)) begin
            w_state_nxt    = ST_SHIFT;
            w_sh_val_nxt   = w_a;
            w_sh_cnt_nxt   = w_n;
            w_sh_dest_nxt  = i_dest_select;
            w_sh_right_nxt = (w_fs == FS_SHRN);
          end else begin
            w_we = 1'b1;
            // Data_in loads leave the flags alone
            if (w_is_shn || !i_md_select) begin
              w_flags_nxt[FLAG_V] = w_v;
              w_flags_nxt[FLAG_C] = w_c;
              w_flags_nxt[FLAG_N] = w_f[MSB];
              w_flags_nxt[FLAG_Z] = (w_f == '0);
            end
          end
        end
      end
      ST_SHIFT: begin
        // load_enable is deliberately ignored for the whole shift
        w_sh_val_nxt = w_step;
        w_sh_cnt_nxt = r_sh_cnt - CNT_LAST;
        if (r_sh_cnt == CNT_LAST) begin
          w_state_nxt         = ST_IDLE;
          w_we                = 1'b1;
          w_waddr             = r_sh_dest;
          w_wdata             = w_step;
          w_done_nxt          = 1'b1;
          w_flags_nxt[FLAG_V] = 1'b0;
          w_flags_nxt[FLAG_C] = w_out_bit;
          w_flags_nxt[FLAG_N] = w_step[MSB];
          w_flags_nxt[FLAG_Z] = (w_step == '0);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sh_val   <= '0;
      r_sh_cnt   <= '0;
      r_sh_dest  <= '0;
      r_sh_right <= 1'b0;
      r_flags    <= '0;
      r_done     <= 1'b0;
    end else begin
      r_sh_val   <= w_sh_val_nxt;
      r_sh_cnt   <= w_sh_cnt_nxt;
      r_sh_dest  <= w_sh_dest_nxt;
      r_sh_right <= w_sh_right_nxt;
      r_flags    <= w_flags_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign o_flags = r_flags;
  assign o_busy  = (r_state == ST_SHIFT);
  assign o_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_datapath_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_datapath_param
// Purpose  : Self-checking bench for datapath_param (WIDTH=32, NREG=8):
//            directed scenarios followed by random operations, all compared
//            against a behavioural model of registers, flags and shifts.
// Revision : 1.0  initial release
// ============================================================================
module tb_datapath_param;

  logic        clk;
  logic        reset;
  logic        le;
  logic [2:0]  dsel, asel, bsel;
  logic [3:0]  fs;
  logic        mb, md;
  logic [31:0] cst, din;
  logic [31:0] o_address_out, o_data_out, o_function_result;
  logic [3:0]  o_flags;
  logic        o_busy, o_done;

  datapath_param #(
    .WIDTH (32),
    .NREG  (8)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .i_load_enable     (le),
    .i_dest_select     (dsel),
    .i_a_select        (asel),
    .i_b_select        (bsel),
    .i_fs              (fs),
    .i_mb_select       (mb),
    .i_md_select       (md),
    .i_constant_in     (cst),
    .i_data_in         (din),
    .o_address_out     (o_address_out),
    .o_data_out        (o_data_out),
    .o_function_result (o_function_result),
    .o_flags           (o_flags),
    .o_busy            (o_busy),
    .o_done            (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_reg [8];
  logic [3:0]  m_flags;          // {V,C,N,Z}
  logic        m_busy, m_done;
  int          m_left;           // cycles until shift writeback
  logic [31:0] m_res;
  logic        m_cout;
  int          m_dest;

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    m_flags = '0; m_busy = 0; m_done = 0; m_left = 0;
  endtask

  function automatic logic ovf(input longint r);
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  task automatic model_fu(input int f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic c, output logic v);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = a; c = 0; v = 0;
    case (f)
      0: begin r = a + b; c = (longint'(a) + longint'(b)) > 64'hFFFF_FFFF; v = ovf(sa + sb); end
      1: begin r = a - b; c = (a >= b); v = ovf(sa - sb); end
      2: begin r = a + 1; c = (a == 32'hFFFF_FFFF); v = ovf(sa + 1); end
      3: begin r = a - 1; c = (a == 0); v = ovf(sa - 1); end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      7: r = ~a;
      8: r = b;
      9:  begin r = a * 2; c = a[31]; end
      10: begin r = a / 2; c = a[0]; end
      default: r = a;
    endcase
  endtask

  // One clock cycle: check combinational outputs before the edge, advance
  // the model, then check registered outputs just after the edge.
  task automatic run_cycle();
    logic [31:0] a, b, f, wb;
    logic c, v;
    int n;
    bit shn;
    @(negedge clk);
    a   = m_reg[asel];
    b   = mb ? cst : m_reg[bsel];
    shn = (fs == 4'd12) || (fs == 4'd13);
    model_fu(int'(fs), a, b, f, c, v);
    wb  = (md && !shn) ? din : f;
    check("address_out", o_address_out, a);
    check("data_out", o_data_out, b);
    check("function_result", o_function_result, wb);
    m_done = 0;
    if (!reset) begin
      model_clear();
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_reg[m_dest] = m_res;
        m_flags = {1'b0, m_cout, m_res[31], m_res == 0};
        m_busy = 0;
        m_done = 1;
      end
    end else if (le) begin
      n = int'(b[4:0]);
      if (shn && n != 0) begin
        m_busy = 1; m_left = n; m_dest = int'(dsel);
        if (fs == 4'd12) begin m_res = a << n; m_cout = a[32 - n]; end
        else             begin m_res = a >> n; m_cout = a[n - 1];  end
      end else begin
        m_reg[dsel] = wb;
        if (shn || !md) m_flags = {v, c, wb[31], wb == 0};
      end
    end
    @(posedge clk);
    #1;
    check("flags", {28'd0, o_flags}, {28'd0, m_flags});
    check("busy", {31'd0, o_busy}, {31'd0, m_busy});
    check("done", {31'd0, o_done}, {31'd0, m_done});
  endtask

  task automatic op(input logic le_, input int d, input int a_, input int b_, input int f_,
                    input logic mb_, input logic md_, input logic [31:0] c_, input logic [31:0] din_);
    le = le_; dsel = 3'(d); asel = 3'(a_); bsel = 3'(b_); fs = 4'(f_);
    mb = mb_; md = md_; cst = c_; din = din_;
    run_cycle();
  endtask

  task automatic idle();
    op(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Read a register through port A and compare with a hard expectation
  task automatic peek(input string tag, input int r, input logic [31:0] exp);
    op(0, 0, r, 0, 0, 0, 0, 0, 0);
    check(tag, o_address_out, exp);
  endtask

  task automatic randomize_inputs();
    le   = ($urandom_range(0, 9) < 7);
    dsel = 3'($urandom);
    asel = 3'($urandom);
    bsel = 3'($urandom);
    fs   = 4'($urandom);
    mb   = 1'($urandom);
    md   = ($urandom_range(0, 3) == 0);
    cst  = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 8);
    din  = $urandom;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_clear();
    reset = 1'b0;
    le = 0; dsel = 0; asel = 0; bsel = 0; fs = 0; mb = 0; md = 0; cst = 0; din = 0;

    // Reset held with toggling controls
    for (int i = 0; i < 5; i++) begin
      randomize_inputs();
      run_cycle();
    end
    for (int i = 0; i < 8; i++) begin
      asel = 3'(i);
      #1;
      check("reset_reg", o_address_out, 32'h0);
    end
    check("reset_busy", {31'd0, o_busy}, 32'd0);
    reset = 1'b1;

    // ADD overflow and SUB to zero
    op(1, 1, 0, 0, 0, 0, 1, 0, 32'h7FFF_FFFF);
    op(1, 2, 1, 0, 0, 1, 0, 32'h1, 0);
    check("add_ovf_flags", {28'd0, o_flags}, 32'hA);
    peek("add_ovf_r2", 2, 32'h8000_0000);
    op(1, 5, 1, 1, 1, 0, 0, 0, 0);
    check("sub_zero_flags", {28'd0, o_flags}, 32'h5);

    // Data_in load keeps flags
    op(1, 6, 0, 0, 0, 0, 1, 0, 32'hDEAD_BEEF);
    check("din_flags_kept", {28'd0, o_flags}, 32'h5);
    peek("din_r6", 6, 32'hDEAD_BEEF);

    // SHLN by 4
    op(1, 3, 0, 0, 0, 0, 1, 0, 32'h8000_0001);
    op(1, 3, 3, 0, 12, 1, 0, 32'd4, 0);
    for (int i = 0; i < 4; i++) idle();
    check("shln_flags", {28'd0, o_flags}, 32'h0);
    peek("shln_r3", 3, 32'h0000_0010);

    // SHRN by 1 of 3
    op(1, 4, 0, 0, 0, 0, 1, 0, 32'h3);
    op(1, 4, 4, 0, 13, 1, 0, 32'd1, 0);
    idle();
    check("shrn1_flags", {28'd0, o_flags}, 32'h4);
    peek("shrn1_r4", 4, 32'h1);

    // ADD to r4 ignored while busy, including the busy-falling cycle
    op(1, 7, 0, 0, 0, 0, 1, 0, 32'h10);
    op(1, 7, 7, 0, 13, 1, 0, 32'd3, 0);
    for (int i = 0; i < 3; i++) op(1, 4, 1, 0, 0, 1, 0, 32'h1, 0);
    check("busy_ignore_r4", m_reg[4], 32'h1);
    op(1, 4, 1, 0, 0, 1, 0, 32'h1, 0);
    peek("reissue_r4", 4, 32'h8000_0000);
    peek("shrn3_r7", 7, 32'h2);

    // Reset in the second cycle of a 5-cycle shift
    op(1, 5, 0, 0, 0, 0, 1, 0, 32'hF0);
    op(1, 5, 5, 0, 13, 1, 0, 32'd5, 0);
    idle();
    reset = 1'b0;
    model_clear();
    #1;
    check("midreset_busy", {31'd0, o_busy}, 32'd0);
    idle();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) idle();
    peek("midreset_r5", 5, 32'h0);

    // Random operations
    for (int i = 0; i < 600; i++) begin
      randomize_inputs();
      run_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
